// File: rtl/rand_delay_timer.sv
// Random delay timer: samples the LFSR generator, range-limits the sample by masking
// and rejection, then counts the delay down in timebase ticks and pulses expired.
module rand_delay_timer #(
    parameter int MIN_DELAY = 1000,
    parameter int MASK_BITS = 12,
    parameter int RANGE_MAX = 3000,
    parameter int MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        tick,
    input  logic [15:0] numRand,
    output logic        request,
    output logic        busy,
    output logic        expired,
    output logic [15:0] delayVal
);

    localparam logic [15:0] OFF_MASK = 16'((32'd1 << MASK_BITS) - 32'd1);
    localparam logic [15:0] MIN_D    = 16'(MIN_DELAY);
    localparam logic [15:0] RMAX     = 16'(RANGE_MAX);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, COUNT} state_t;

    state_t      state, state_nx;
    logic [15:0] count, count_nx, dly_nx, off;
    logic [1:0]  retry, retry_nx;
    logic        req_nx, exp_nx, accept, last_try, done;

    assign off      = numRand & OFF_MASK;
    assign accept   = (off <= RMAX);
    assign last_try = ({30'd0, retry} + 32'd1) >= 32'(MAX_RETRY);
    // count never loads below 1 with sane parameters; <=1 also guards a zero load
    assign done     = tick && (count <= 16'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = REQ;
            REQ:   state_nx = WAIT;
            WAIT:  state_nx = (accept || last_try) ? COUNT : REQ;
            COUNT: if (done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_comb begin
        req_nx   = (state_nx == REQ);
        exp_nx   = (state == COUNT) && done && !abort;
        count_nx = count;
        dly_nx   = delayVal;
        retry_nx = retry;
        case (state)
            IDLE: if (start) retry_nx = 2'd0;
            WAIT: begin
                if (accept) begin
                    count_nx = MIN_D + off;
                    dly_nx   = MIN_D + off;
                end else if (last_try) begin
                    count_nx = MIN_D + RMAX;
                    dly_nx   = MIN_D + RMAX;
                end else begin
                    retry_nx = retry + 2'd1;
                end
            end
            COUNT: if (tick) count_nx = done ? 16'd0 : count - 16'd1;
            default: ;
        endcase
        // abort cancels any load in flight; delayVal keeps its previous value
        if (abort) begin
            count_nx = 16'd0;
            dly_nx   = delayVal;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            request  <= 1'b0;
            busy     <= 1'b0;
            expired  <= 1'b0;
            delayVal <= 16'd0;
            count    <= 16'd0;
            retry    <= 2'd0;
        end else begin
            request  <= req_nx;
            busy     <= (state_nx != IDLE);
            expired  <= exp_nx;
            delayVal <= dly_nx;
            count    <= count_nx;
            retry    <= retry_nx;
        end
    end

endmodule

// File: tb/tb_rand_delay_timer.sv
// Randomized bench for rand_delay_timer against a transaction-level timing model.
module tb_rand_delay_timer;

    logic        clk = 1'b0;
    logic        rst, start, abort, tick;
    logic [15:0] numRand;
    logic        request, busy, expired;
    logic [15:0] delayVal;
    int          total = 0;
    int          bad = 0;

    rand_delay_timer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .tick(tick),
        .numRand(numRand), .request(request), .busy(busy), .expired(expired),
        .delayVal(delayVal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: number of samples taken and the delay they produce
    function automatic void model(input logic [15:0] s0, s1, s2, output int n, output int nd);
        logic [15:0] s [3];
        int off;
        s[0] = s0; s[1] = s1; s[2] = s2;
        n = 0; nd = 0;
        for (int i = 0; i < 3; i++) begin
            n++;
            off = int'(s[i]) % 4096;
            if (off <= 3000) begin nd = 1000 + off; break; end
            if (i == 2) nd = 4000;
        end
    endfunction

    // Called at a negedge with the DUT idle; start is sampled at the next edge (E0).
    // ab >= 0 aborts once ab ticks have been consumed; ab == nd-1 also forces the terminal tick.
    task automatic run(input logic [15:0] s0, s1, s2, input int gap, input int ab);
        logic [15:0] s [3];
        int n, nd, used, kdone, si, junk_at;
        bit aborted, exp_req;
        s[0] = s0; s[1] = s1; s[2] = s2;
        model(s0, s1, s2, n, nd);
        used = 0; kdone = -1; si = 0; junk_at = -1; aborted = 0;
        start = 1'b1; abort = 1'b0; tick = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            exp_req = (k < 2 * n) && (k % 2 == 0);
            chk("request", 32'(request), 32'(exp_req));
            chk("busy", 32'(busy), 32'((kdone < 0) || (k <= kdone)));
            chk("expired", 32'(expired), 32'((kdone >= 0) && (k == kdone + 1) && !aborted));
            if (k == 2 * n) chk("delayVal_load", 32'(delayVal), 32'(nd));
            if (kdone >= 0 && k == kdone + 1) begin
                if (aborted) chk("delayVal_hold", 32'(delayVal), 32'(nd));
                start = 1'b0; abort = 1'b0; tick = 1'b0;
                return;
            end
            if (exp_req) begin
                numRand = s[si]; si++; junk_at = k + 2;
            end else if (k == junk_at) begin
                numRand = 16'($urandom);
            end
            tick  = ($urandom_range(0, gap) == 0);
            start = (k >= 1) && ($urandom_range(0, 31) == 0);
            abort = 1'b0;
            if (k >= 2 * n) begin
                if (ab >= 0 && used == ab) begin
                    abort = 1'b1; aborted = 1;
                    if (ab == nd - 1) tick = 1'b1;
                    kdone = k;
                end else if (tick) begin
                    used++;
                    if (used == nd) kdone = k;
                end
            end
        end
        chk("timeout", 32'(kdone), 32'hFFFF_FFFF);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; tick = 1'b0; numRand = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_request", 32'(request), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_expired", 32'(expired), 0);
        chk("rst_delayVal", 32'(delayVal), 0);
        rst = 1'b1;
        @(negedge clk);

        // abort together with start in IDLE must not leave IDLE
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", 32'(busy), 0);
        chk("abort_start_req", 32'(request), 0);
        @(negedge clk);
        chk("abort_start_busy2", 32'(busy), 0);

        run(16'h0123, 16'h0, 16'h0, 1, -1);          // basic, delay 1291
        run(16'h0FFF, 16'h0010, 16'h0, 0, -1);       // one rejection, delay 1016
        run(16'hFFFF, 16'hFFFF, 16'hFFFF, 0, -1);    // retry limit, delay 4000
        run(16'hF005, 16'h0, 16'h0, 0, -1);          // upper bits masked, delay 1005
        run(16'h0BB8, 16'h0, 16'h0, 0, -1);          // offset exactly RANGE_MAX
        run(16'h0BB9, 16'h0000, 16'h0, 0, -1);       // RANGE_MAX+1 rejected, then zero offset
        run(16'h0234, 16'h0, 16'h0, 0, 1564 - 500);  // abort with count = 500
        run(16'h0064, 16'h0, 16'h0, 0, 1100 - 1);    // abort on terminal tick

        // reset asserted while in WAIT
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; numRand = 16'h0050;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_request", 32'(request), 0);
        chk("rst_mid_expired", 32'(expired), 0);
        chk("rst_mid_delayVal", 32'(delayVal), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 32'(busy), 0);
        run(16'h0050, 16'h0, 16'h0, 0, -1);

        for (int r = 0; r < 5; r++)
            run(16'($urandom), 16'($urandom), 16'($urandom), 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rand_delay_timer.md
# rand_delay_timer

Consumer side of the random-number request interface. On a start pulse it issues a one-cycle `request` to the LFSR random generator and captures the returned `numRand` one cycle later. It range-limits the value by masking and rejection sampling, then counts the resulting delay down in external timebase ticks and pulses `expired`. The game controller uses it for the unpredictable wait before each reaction prompt.

## Interface
- MIN_DELAY, 1000: fixed delay floor, in ticks.
- MASK_BITS, 12: number of low `numRand` bits used as the random offset.
- RANGE_MAX, 3000: largest accepted masked offset; larger values are rejected.
- MAX_RETRY, 3: number of rejected samples after which the offset is forced to RANGE_MAX.
- Constraint: MIN_DELAY + RANGE_MAX ≤ 65535, and RANGE_MAX < 2^MASK_BITS.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse that begins a delay; honoured only in IDLE.
- abort  in  1  synchronous cancel, valid in any state.
- tick  in  1  timebase enable (for example 1 ms), one clk wide.
- numRand  in  16  random value from the generator; valid the cycle after `request`.
- request  out  1  registered; high for exactly one cycle per sample.
- busy  out  1  registered; high whenever state ≠ IDLE.
- expired  out  1  registered one-cycle pulse when the delay completes.
- delayVal  out  16  loaded delay (MIN_DELAY + offset); holds until the next load.

## Operation
- States: IDLE, REQ, WAIT, COUNT. Internal registers: `count[15:0]` and `retry[1:0]`.
- **IDLE:** `start`=1 and `abort`=0 → REQ, `request`<=1, `retry`<=0.
- **REQ:** `request` is high during this cycle, because the generator latches on this edge. The FSM moves to WAIT and sets `request`<=0.
- **WAIT:** `numRand` is valid. At the edge leaving WAIT, let `off` = `numRand[MASK_BITS-1:0]`.
  - `off` ≤ RANGE_MAX: `count`<=MIN_DELAY+off, `delayVal`<=same, go to COUNT.
  - `off` > RANGE_MAX and `retry`+1 < MAX_RETRY: `retry`++, go to REQ, `request`<=1.
  - `off` > RANGE_MAX and `retry`+1 = MAX_RETRY: load MIN_DELAY+RANGE_MAX, go to COUNT.
- **COUNT:**
  - `tick` with `count` > 1: `count`--.
  - `tick` with `count` = 1: `count`<=0, `expired`<=1, go to IDLE.
- **abort:** from any state, go to IDLE on the next edge. `request`, `expired` and `count` are cleared; `delayVal` keeps its value; no `expired` is generated.
- **Priority:** abort > start. Abort and a terminal tick in the same cycle means abort wins and there is no `expired`.
- `start` outside IDLE is ignored; there is no queueing.
- `tick` outside COUNT is ignored. This includes the WAIT→COUNT loading edge.
- Arithmetic is 16-bit unsigned. The parameter constraint rules out overflow.

## Timing
- Reset values: state=IDLE, `request`=0, `busy`=0, `expired`=0, `delayVal`=0, `count`=0, `retry`=0.
- Cycle timeline with no rejection:
  - `start` is sampled at edge E0; `request` and `busy` are high in cycle E0–E1.
  - The generator captures at E1.
  - Evaluation and load happen at E2; COUNT begins in cycle E2–E3.
- Each rejection adds 2 cycles (REQ + WAIT).
- Total latency is N ticks after load, where N = `delayVal`. `expired` is high in the cycle after the edge that consumed the N-th tick. `busy` falls on that same edge.
- After the pulse, `start` is accepted again on the very next edge (back-to-back operation).
- Reset asserted mid-operation forces all reset values immediately. A `start` pulse must follow deassertion before anything happens.

## Test plan
- Basic: `numRand`=0x0123 returned after `request`, then 1291 ticks → `delayVal`=1291. `expired` pulses for 1 cycle after the 1291st tick. `request` was high exactly 1 cycle.
- Rejection: the first sample returns 0x0FFF (4095 > 3000), the second returns 0x0010 → 2 `request` pulses, `delayVal`=1016, and the load happens 2 cycles later than in the basic case.
- Retry limit: three samples each return 0xFFFF → 3 `request` pulses, `delayVal`=4000, count proceeds normally.
- Upper bits masked: `numRand`=0xF005 → `delayVal`=1005.
- Abort and ignore:
  - `abort` at `count`=500 → `busy` falls next edge, no `expired`.
  - `start` during COUNT → no new `request`.
  - `abort`+`start` in IDLE → stays IDLE.
- Reset mid-WAIT → all outputs return to reset values asynchronously. A subsequent `start` operates normally.
